// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out MSB-first,
// repeating it a programmable number of times with an optional zero-gap between frames.
module pattern_serial_tx #(
   parameter int unsigned MAXLEN = 8,
   parameter int unsigned LENW   = 4,
   parameter int unsigned CNTW   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LENW-1:0]   len,
   input  logic [CNTW-1:0]   rpt,
   input  logic [CNTW-1:0]   gap,
   output logic              x_out,
   output logic              valid,
   output logic              frame,
   output logic              busy,
   output logic              done
);

   localparam int unsigned IW = $clog2(MAXLEN);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

   state_e              state_q, state_d;
   logic [MAXLEN-1:0]   pat_q, pat_d;
   logic [IW-1:0]       msb_q, msb_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CNTW-1:0]     frm_q, frm_d;
   logic [CNTW-1:0]     gap_q, gap_d;
   logic [CNTW-1:0]     gcnt_q, gcnt_d;
   logic                x_q, x_d, valid_q, valid_d, frame_q, frame_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic [LENW-1:0]     len_clamp, len_m1;
   logic [IW-1:0]       idx_nx;

   always_comb begin
      len_clamp = (len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : len;
      len_m1    = len_clamp - LENW'(1);
      idx_nx    = idx_q - IW'(1);
   end

   // Outputs are computed for the cycle following the edge, so they come straight from flops.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      msb_d   = msb_q;
      idx_d   = idx_q;
      frm_d   = frm_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      x_d     = 1'b0;
      valid_d = 1'b0;
      frame_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (len != '0)) begin
                  state_d = S_SEND;
                  pat_d   = pattern;
                  msb_d   = len_m1[IW-1:0];
                  idx_d   = len_m1[IW-1:0];
                  frm_d   = rpt;
                  gap_d   = gap;
                  x_d     = pattern[len_m1[IW-1:0]];
                  valid_d = 1'b1;
                  frame_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
            S_SEND: begin
               if (idx_q != '0) begin
                  idx_d   = idx_nx;
                  x_d     = pat_q[idx_nx];
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end else if (frm_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  frm_d  = frm_q - CNTW'(1);
                  busy_d = 1'b1;
                  if (gap_q == '0) begin
                     idx_d   = msb_q;
                     x_d     = pat_q[msb_q];
                     valid_d = 1'b1;
                     frame_d = 1'b1;
                  end else begin
                     state_d = S_GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end
            S_GAP: begin
               busy_d = 1'b1;
               // gcnt_q counts the gap cycles still showing, including the current one
               if (gcnt_q == CNTW'(1)) begin
                  state_d = S_SEND;
                  idx_d   = msb_q;
                  x_d     = pat_q[msb_q];
                  valid_d = 1'b1;
                  frame_d = 1'b1;
               end else begin
                  gcnt_d = gcnt_q - CNTW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         msb_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         x_q     <= 1'b0;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         msb_q   <= msb_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         x_q     <= x_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x_out = x_q;
   assign valid = valid_q;
   assign frame = frame_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Bench for pattern_serial_tx: directed scenarios plus random transfers checked
// cycle by cycle against an expected-output list built from the frame/gap rules.
module tb_pattern_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, abort;
   logic [7:0] pattern;
   logic [3:0] len, rpt, gap;
   logic       x_out, valid, frame, busy, done;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   pattern_serial_tx #(.MAXLEN(8), .LENW(4), .CNTW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .rpt(rpt), .gap(gap),
      .x_out(x_out), .valid(valid), .frame(frame), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] outs();
      return {x_out, valid, frame, busy, done};
   endfunction

   // Called at a negedge; leaves the bench at a negedge with start low.
   task automatic run_xfer(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                           input logic [3:0] gp, input bit disturb, input string tag);
      logic [4:0] exp_q[$];
      int lc;
      lc = (ln > 4'd8) ? 8 : int'(ln);
      if (lc != 0) begin
         for (int f = 0; f <= int'(rp); f++) begin
            for (int b = lc - 1; b >= 0; b--)
               exp_q.push_back({pat[b], 1'b1, (b == lc - 1), 1'b1, 1'b0});
            if (f < int'(rp))
               for (int g = 0; g < int'(gp); g++) exp_q.push_back(5'b00010);
         end
         exp_q.push_back(5'b00001);
      end
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      pattern = pat; len = ln; rpt = rp; gap = gp; start = 1'b1;
      foreach (exp_q[i]) begin
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, i), 32'(outs()), 32'(exp_q[i]));
         start = 1'b0;
         if (disturb && exp_q[i][1]) begin
            start   = 1'b1;
            pattern = 8'($urandom);
            len     = 4'($urandom);
            rpt     = 4'($urandom);
            gap     = 4'($urandom);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      pattern = '0; len = '0; rpt = '0; gap = '0;
      #1 check("reset_outs", 32'(outs()), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_xfer(8'b0000_1011, 4'd4, 4'd0, 4'd0, 1'b0, "single");
      run_xfer(8'b0000_1011, 4'd4, 4'd1, 4'd0, 1'b0, "b2b");
      run_xfer(8'b0000_1011, 4'd4, 4'd2, 4'd2, 1'b0, "gapped");
      run_xfer(8'hA5, 4'd0, 4'd1, 4'd1, 1'b0, "len0");
      run_xfer(8'hC3, 4'd12, 4'd0, 4'd0, 1'b0, "clamp");
      run_xfer(8'b0000_1011, 4'd4, 4'd1, 4'd1, 1'b1, "restart_ign");

      // abort at cycle 3, then restart one cycle later
      pattern = 8'b0000_1011; len = 4'd4; rpt = 4'd0; gap = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0; check("abort_c1", 32'(outs()), 32'b11110);
      @(negedge clk); check("abort_c2", 32'(outs()), 32'b01010);
      @(negedge clk); check("abort_c3", 32'(outs()), 32'b11010);
      abort = 1'b1;
      @(negedge clk); check("abort_c4", 32'(outs()), 32'd0);
      abort = 1'b0;
      run_xfer(8'b0000_1011, 4'd4, 4'd0, 4'd0, 1'b0, "after_abort");

      // abort and start together: abort wins
      abort = 1'b1; start = 1'b1;
      @(negedge clk); check("abort_vs_start", 32'(outs()), 32'd0);
      abort = 1'b0; start = 1'b0;
      @(negedge clk); check("abort_vs_start_idle", 32'(outs()), 32'd0);

      // asynchronous reset during cycle 2
      pattern = 8'b0000_1011; len = 4'd4; rpt = 4'd3; gap = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0; check("rst_c1", 32'(outs()), 32'b11110);
      @(posedge clk); #2 rst = 1'b1;
      #1 check("rst_async", 32'(outs()), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); check("rst_idle", 32'(outs()), 32'd0);
      run_xfer(8'b0000_1011, 4'd4, 4'd0, 4'd0, 1'b0, "after_rst");

      for (int t = 0; t < 30; t++)
         run_xfer(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 1'($urandom), $sformatf("rand%0d", t));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
